led_blink_ctrl: RTL and testbench
=================================

// Module: led_blink_ctrl
// PURPOSE
//  Sequencer for the board status LED. Replaces the free-running counter-bit blink.
//  Accepts mode/rate/count configuration over a valid/ready handshake and drives one LED:
//  - off, on or continuous blink at a power-of-two half-period;
//  - a counted burst of N blinks, with a done pulse at the end.
//  Sits between the system control logic and the LED pin in the top level, on the 50 MHz clock.
// PARAMETERS
//  DIV_W    32  prescaler counter width; maximum half-period is 2^(DIV_W-1) cycles
//  RATE_W    5  width of cfg_rate; must satisfy 2^RATE_W >= DIV_W
//  CNT_W     8  width of cfg_count, the burst blink count
// PORTS
//  clk        in   1       system clock, 50 MHz
//  rst        in   1       synchronous, active-high reset
//  cfg_valid  in   1       configuration offered
//  cfg_ready  out  1       controller can accept a configuration
//  cfg_mode   in   2       0 OFF, 1 ON, 2 BLINK, 3 BURST
//  cfg_rate   in   RATE_W  half-period = 2^cfg_rate clock cycles
//  cfg_count  in   CNT_W   number of blinks in BURST; ignored in other modes
//  led        out  1       LED drive, 1 = lit
//  busy       out  1       high while a BURST is in progress
//  done       out  1       one-cycle pulse when a BURST completes
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high (clk / rst).
//  - Reset values:
//    - state OFF, led 0, busy 0, done 0, cfg_ready 1;
//    - prescaler 0, burst counter 0, latched rate 0.
//  - Handshake: a configuration is accepted on a rising edge with cfg_valid & cfg_ready.
//    - cfg_ready = 1 in OFF, ON and BLINK; cfg_ready = 0 in BURST.
//    - cfg_* are ignored when not accepted. A held cfg_valid does not re-trigger after acceptance.
//  - On acceptance at edge T:
//    - mode, rate and count are latched; the prescaler clears to 0.
//    - The new state is visible from T+1; there is no decoding latency beyond one register.
//  - Rate handling: cfg_rate >= DIV_W is clamped to DIV_W-1.
//    - tick = prescaler reaches 2^rate - 1; the prescaler then wraps to 0.
//    - rate 0 gives a tick every cycle.
//  - States:
//    - OFF: led 0, no ticks used.
//    - ON: led 1.
//    - BLINK: led = 1 from T+1, toggles on every tick, runs until a new config is accepted.
//    - BURST: busy 1, led = 1 from T+1, toggles on every tick.
//      - Each 1->0 toggle decrements the remaining count.
//      - When the remaining count reaches 0 and the following off-phase tick occurs:
//        done = 1 for one cycle, state -> OFF, busy 0, cfg_ready 1, all in the same cycle.
//      - Overall, done is high in cycle T+1+2N*2^rate for a burst of N.
//  - Boundary conditions:
//    - BURST with count 0: no LED activity; done pulses at T+1 and the state returns to OFF at T+1.
//    - Config accepted on the same edge as a tick: the config wins, the tick is discarded,
//      and the prescaler restarts from 0.
//    - Reset mid-burst: immediate OFF, led 0, busy 0, and no done pulse.
//    - The prescaler and burst counter never overflow; the prescaler wraps only via tick.
//    - Re-accepting an identical BLINK config restarts the phase (led = 1 at T+1).
// STRUCTURE
//  - Package led_ctrl_pkg:
//    - localparams MODE_OFF=2'd0, MODE_ON=2'd1, MODE_BLINK=2'd2, MODE_BURST=2'd3;
//    - state encoding for the FSM;
//    - default DIV_W/RATE_W/CNT_W values.
//  - Sub-module led_prescaler (clk, rst, clr, rate, tick):
//    - DIV_W counter with clamp and wrap;
//    - one-cycle tick at 2^rate - 1.
//  - Top level: FSM, config latch, burst counter, output registers; all outputs registered.
// TESTING
//  1. Reset, then idle 10 cycles -> led 0, busy 0, done 0, cfg_ready 1 throughout.
//  2. Accept ON, then OFF -> led 1 from the cycle after the first accept; led 0 from the cycle after the second.
//  3. Accept BLINK, rate 3 -> led 1 for 8 cycles, 0 for 8 cycles, repeating; check 4 full periods.
//  4. Accept BURST, rate 2, count 3 -> 3 pulses of 4 cycles high / 4 low; done pulses at T+25;
//     cfg_ready stays 0 with cfg_valid held 1 mid-burst, and that config is never accepted.
//  5. BURST count 0; then rate 31 with DIV_W=8 -> done at T+1 with led never 1;
//     the clamp gives a half-period of 128 cycles.
//  6. Assert rst mid-BURST (count 5, rate 1) -> led 0, busy 0 the next cycle; no done; cfg_ready 1.
//  7. Accept BLINK on the same edge as a tick -> led 1 at T+1, and the next toggle is exactly 2^rate cycles later.

Source files
------------

// File: rtl/led_blink_ctrl_pkg.sv
// Shared definitions for the status LED sequencer: configuration mode codes,
// FSM state encoding and default widths.
package led_ctrl_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    localparam int DEF_DIV_W  = 32;
    localparam int DEF_RATE_W = 5;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_BLINK = 2'd2,
        ST_BURST = 2'd3
    } led_state_e;

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Configuration handshake between system control logic (master) and the
// LED sequencer (slave).
//   cfg_valid  master -> slave  configuration offered
//   cfg_ready  slave -> master  sequencer can accept a configuration
//   cfg_mode   master -> slave  OFF / ON / BLINK / BURST
//   cfg_rate   master -> slave  half-period exponent (2^rate cycles)
//   cfg_count  master -> slave  blink count for BURST
interface led_blink_ctrl_if
    import led_ctrl_pkg::*;
#(
    parameter int RATE_W = DEF_RATE_W,
    parameter int CNT_W  = DEF_CNT_W
);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_mode;
    logic [RATE_W-1:0] cfg_rate;
    logic [CNT_W-1:0]  cfg_count;

    modport master (
        output cfg_valid, cfg_mode, cfg_rate, cfg_count,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_rate, cfg_count,
        output cfg_ready
    );

endinterface

// File: rtl/led_blink_ctrl_prescaler.sv
// Half-period prescaler for the LED sequencer.
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   clr   in   restart the count from 0 (new configuration accepted)
//   rate  in   half-period exponent; values >= DIV_W clamp to DIV_W-1
//   tick  out  high for the one cycle in which the count equals 2^rate - 1
module led_prescaler
    import led_ctrl_pkg::*;
#(
    parameter int DIV_W  = DEF_DIV_W,
    parameter int RATE_W = DEF_RATE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [RATE_W-1:0] rate,
    output logic              tick
);

    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  cnt_d;
    logic [DIV_W-1:0]  term;
    logic [RATE_W-1:0] rate_c;

    always_comb begin
        rate_c = rate;
        if (int'(rate) >= DIV_W) begin
            rate_c = RATE_W'(DIV_W - 1);
        end
    end

    // The clamp keeps the terminal count inside DIV_W bits, so the counter
    // always wraps through tick and can never roll over on its own.
    assign term = (DIV_W'(1) << rate_c) - DIV_W'(1);
    assign tick = (cnt_q == term);

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_blink_ctrl.sv
// Status LED sequencer: off, on, continuous blink, or a counted burst of
// blinks ending in a one-cycle done pulse. All outputs are registered.
//   clk   in   system clock (50 MHz)
//   rst   in   synchronous active-high reset
//   cfg   slave side of the configuration handshake
//   led   out  LED drive, 1 = lit
//   busy  out  high while a burst is in progress
//   done  out  one-cycle pulse when a burst completes
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_OFF   | LED dark, ready for configuration
// ST_ON    | LED lit steadily
// ST_BLINK | LED toggles every tick until reconfigured
// ST_BURST | LED toggles every tick, counting blinks; not ready, busy
module led_blink_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int DIV_W  = DEF_DIV_W,
    parameter int RATE_W = DEF_RATE_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    led_blink_ctrl_if.slave  cfg,
    output logic             led,
    output logic             busy,
    output logic             done
);

    led_state_e        state_q, state_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              accept;
    logic              tick;

    // hold_q blocks a cfg_valid that stays high after its own acceptance
    // from being taken again; it releases once cfg_valid drops.
    assign accept = cfg.cfg_valid & ready_q & ~hold_q;

    led_prescaler #(
        .DIV_W  (DIV_W),
        .RATE_W (RATE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .rate (rate_q),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        rate_d  = rate_q;
        hold_d  = hold_q & cfg.cfg_valid;

        if (accept) begin
            // A tick on the accepting edge is discarded: the new phase starts here.
            hold_d = 1'b1;
            rate_d = cfg.cfg_rate;
            cnt_d  = cfg.cfg_count;
            case (cfg.cfg_mode)
                MODE_ON: begin
                    state_d = ST_ON;
                    led_d   = 1'b1;
                end
                MODE_BLINK: begin
                    state_d = ST_BLINK;
                    led_d   = 1'b1;
                end
                MODE_BURST: begin
                    if (cfg.cfg_count == '0) begin
                        state_d = ST_OFF;
                        led_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_BURST;
                        led_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    led_d   = 1'b0;
                end
            endcase
        end else if (tick) begin
            case (state_q)
                ST_BLINK: begin
                    led_d = ~led_q;
                end
                ST_BURST: begin
                    // Count on the falling toggle; finish on the off-phase tick after the last one.
                    if (led_q) begin
                        led_d = 1'b0;
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (cnt_q == '0) begin
                        state_d = ST_OFF;
                        done_d  = 1'b1;
                    end else begin
                        led_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        ready_d = (state_d != ST_BURST);
        busy_d  = (state_d == ST_BURST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            hold_q  <= 1'b0;
            cnt_q   <= '0;
            rate_q  <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            rate_q  <= rate_d;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign led           = led_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for the status LED sequencer.
module tb_led_blink_ctrl;
    import led_ctrl_pkg::*;

    localparam int DIV_W  = 8;
    localparam int RATE_W = 5;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic led, busy, done;

    led_blink_ctrl_if #(.RATE_W(RATE_W), .CNT_W(CNT_W)) cfg_if ();

    led_blink_ctrl #(
        .DIV_W  (DIV_W),
        .RATE_W (RATE_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cfg  (cfg_if),
        .led  (led),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic              valid;
        logic [1:0]        mode;
        logic [RATE_W-1:0] rate;
        logic [CNT_W-1:0]  count;
        logic              e_led;
        logic              e_busy;
        logic              e_done;
        logic              e_ready;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_led, input logic e_busy,
                             input logic e_done, input logic e_ready);
        check({tag, ".led"},   led,              e_led);
        check({tag, ".busy"},  busy,             e_busy);
        check({tag, ".done"},  done,             e_done);
        check({tag, ".ready"}, cfg_if.cfg_ready, e_ready);
    endtask

    // Offer a configuration in the current cycle; returns in the cycle after the accepting edge.
    task automatic accept(input logic [1:0] mode, input int rate, input int count);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_mode  = mode;
        cfg_if.cfg_rate  = RATE_W'(rate);
        cfg_if.cfg_count = CNT_W'(count);
        @(posedge clk);
        #1;
        cfg_if.cfg_valid = 1'b0;
    endtask

    // Check cycles k0..k1 after an accept (cycle 1 = first cycle after the accepting edge).
    task automatic run_check(input string tag, input int k0, input int k1, input int half,
                             input logic [1:0] kind, input int nb);
        logic e_led, e_busy, e_done, e_ready;
        bit   active;
        for (int k = k0; k <= k1; k++) begin
            e_busy  = 1'b0;
            e_done  = 1'b0;
            e_ready = 1'b1;
            case (kind)
                MODE_ON:    e_led = 1'b1;
                MODE_BLINK: e_led = (((k - 1) / half) % 2 == 0);
                MODE_BURST: begin
                    active  = (k <= 2 * nb * half);
                    e_led   = active && (((k - 1) / half) % 2 == 0);
                    e_busy  = active;
                    e_done  = (k == 2 * nb * half + 1);
                    e_ready = !active;
                end
                default:    e_led = 1'b0;
            endcase
            check_all($sformatf("%s[%0d]", tag, k), e_led, e_busy, e_done, e_ready);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_mode  = MODE_OFF;
        cfg_if.cfg_rate  = '0;
        cfg_if.cfg_count = '0;

        // valid, mode, rate, count -> led, busy, done, ready after the edge
        vecs[0]  = '{1'b1, MODE_ON,    5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, MODE_OFF,   5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, MODE_OFF,   5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, MODE_OFF,   5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, MODE_BLINK, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, MODE_BLINK, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, MODE_BLINK, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, MODE_OFF,   5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, MODE_ON,    5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, MODE_OFF,   5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, MODE_BURST, 5'd3, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, MODE_OFF,   5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, MODE_OFF,   5'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        run_check("idle", 1, 10, 1, MODE_OFF, 0);

        // Single-cycle vectors: ON/OFF, held valid not re-triggering, BURST count 0
        for (int i = 0; i < 13; i++) begin
            cfg_if.cfg_valid = vecs[i].valid;
            cfg_if.cfg_mode  = vecs[i].mode;
            cfg_if.cfg_rate  = vecs[i].rate;
            cfg_if.cfg_count = vecs[i].count;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_led, vecs[i].e_busy,
                      vecs[i].e_done, vecs[i].e_ready);
        end
        cfg_if.cfg_valid = 1'b0;
        run_check("post_vec", 1, 2, 1, MODE_OFF, 0);

        // BLINK rate 3: four full periods of 8 on / 8 off
        accept(MODE_BLINK, 3, 0);
        run_check("blink3", 1, 64, 8, MODE_BLINK, 0);

        // BURST rate 2 count 3, with an unaccepted config held mid-burst
        accept(MODE_BURST, 2, 3);
        run_check("burst", 1, 4, 4, MODE_BURST, 3);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_mode  = MODE_ON;
        run_check("burst", 5, 12, 4, MODE_BURST, 3);
        cfg_if.cfg_valid = 1'b0;
        run_check("burst", 13, 30, 4, MODE_BURST, 3);

        // BURST count 0, then rate clamp (31 -> 7 with DIV_W 8)
        accept(MODE_BURST, 4, 0);
        run_check("burst0", 1, 4, 16, MODE_BURST, 0);
        accept(MODE_BLINK, 31, 0);
        run_check("clamp", 1, 300, 128, MODE_BLINK, 0);

        // Reset in the middle of a burst
        accept(MODE_BURST, 1, 5);
        run_check("rst_burst", 1, 6, 2, MODE_BURST, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_mid", 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        run_check("after_rst", 1, 30, 1, MODE_OFF, 0);

        // Identical BLINK re-accepted on a tick edge restarts the phase
        accept(MODE_BLINK, 2, 0);
        run_check("tick_pre", 1, 3, 4, MODE_BLINK, 0);
        accept(MODE_BLINK, 2, 0);
        run_check("tick_acc", 1, 16, 4, MODE_BLINK, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
